// File: rtl/aes128_key_expand_seq.sv
// Iterative AES-128 key schedule: expands one round key per clock into an
// 11-entry register file that the decryptor reads combinationally (rk10 first).
module aes128_key_expand_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         keys_valid
);

  localparam int NR = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] expand_round(input logic [127:0] prev,
                                                input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, rot, sub;
    w0  = prev[127:96];
    w1  = prev[95:64];
    w2  = prev[63:32];
    w3  = prev[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w0  = w0 ^ sub ^ {rc, 24'h0};
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   rk_q [0:NR];
  logic [127:0]   rk_d [0:NR];
  logic [127:0]   prev_key;
  logic [127:0]   next_key;

  // start is a single-cycle request with no ready: it is taken on any edge
  // where the FSM is in IDLE or DONE and silently dropped during EXPAND.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    rk_d     = rk_q;
    prev_key = '0;
    for (int i = 0; i < NR; i++) begin
      if (rnd_q == 4'(i + 1)) prev_key = rk_q[i];
    end
    next_key = expand_round(prev_key, rcon(rnd_q));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rk_d[0] = key;
          rnd_d   = 4'd1;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (rnd_q == 4'(i)) rk_d[i] = next_key;
        end
        if (rnd_q == 4'(NR)) begin
          rnd_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
    end
  end

  // Unregistered read port; indices 11..15 fall through to zero.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_idx == 4'(i)) rd_key = rk_q[i];
    end
  end

  assign busy       = (state_q == S_EXPAND);
  assign keys_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// Bench for aes128_key_expand_seq: directed + random keys against a word-level
// FIPS-197 schedule model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes128_key_expand_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         busy;
  logic         keys_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [7:0]   inv_sbox_m [256];
  logic [127:0] rk_m [11];
  logic [127:0] exp_q [$];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes128_key_expand_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .busy       (busy),
    .keys_valid (keys_valid)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        for (int b = 1; b < 256; b++) begin
          if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
        end
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[a]     = s;
      inv_sbox_m[s] = 8'(a);
    end
  endtask

  task automatic model_schedule(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] st);
    logic [7:0]   o [16];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r + 4*((c + r) % 4)] = inv_sbox_m[st[127 - 8*(r + 4*c) -: 8]];
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = o[b];
    return res;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] st);
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127 - 32*c -: 8];
      a1 = st[119 - 32*c -: 8];
      a2 = st[111 - 32*c -: 8];
      a3 = st[103 - 32*c -: 8];
      res[127 - 32*c -: 8] = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
      res[119 - 32*c -: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
      res[111 - 32*c -: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
      res[103 - 32*c -: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
    end
    return res;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Accepts k on the next edge N, optionally pokes start at N+3 and N+7, and
  // checks {busy,keys_valid} after every edge through N+10.
  task automatic do_expand(input logic [127:0] k, input bit inject);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    check("accept_flags", 128'({busy, keys_valid}), 128'b10);
    for (int e = 1; e <= 10; e++) begin
      if (inject && (e == 3 || e == 7)) begin
        @(negedge clk);
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e < 10) check($sformatf("expand_flags_e%0d", e), 128'({busy, keys_valid}), 128'b10);
      else        check("done_flags", 128'({busy, keys_valid}), 128'b01);
    end
  endtask

  task automatic read_check(input string tag, input int idx, input logic [127:0] exp);
    @(negedge clk);
    rd_idx = 4'(idx);
    #1;
    check(tag, rd_key, exp);
  endtask

  // Scoreboard: expected round keys queued in decryptor order rk10..rk0.
  task automatic check_keys(input logic [127:0] k);
    logic [127:0] exp;
    model_schedule(k);
    for (int r = 10; r >= 0; r--) exp_q.push_back(rk_m[r]);
    for (int r = 10; r >= 0; r--) begin
      @(negedge clk);
      rd_idx = 4'(r);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("rk%0d", r), rd_key, exp);
    end
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_flags"}, 128'({busy, keys_valid}), 128'b00);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), rd_key, 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic decrypt_check(input logic [127:0] ct, input logic [127:0] pt);
    logic [127:0] st;
    @(negedge clk);
    rd_idx = 4'd10;
    #1;
    st = ct ^ rd_key;
    for (int r = 9; r >= 0; r--) begin
      st = inv_shift_sub(st);
      @(negedge clk);
      rd_idx = 4'(r);
      #1;
      st = st ^ rd_key;
      if (r > 0) st = inv_mix(st);
    end
    check("decrypt", st, pt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] rk;
    rst_n  = 1'b1;
    start  = 1'b0;
    key    = '0;
    rd_idx = '0;
    init_sbox();

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 128'({busy, keys_valid}), 128'b00);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      check($sformatf("reset_rd%0d", i), rd_key, 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 vector
    do_expand(K1, 1'b0);
    read_check("fips_rk1", 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    read_check("fips_rk10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    read_check("fips_rk0", 0, K1);
    check_keys(K1);
    decrypt_check(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);

    // asynchronous reset from DONE
    async_reset_check("rst_done");

    // starts during EXPAND are ignored
    do_expand(K1, 1'b1);
    check_keys(K1);

    // restart from DONE with the second key
    do_expand(K2, 1'b0);
    read_check("k2_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_check("k2_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 11; i < 16; i++) read_check($sformatf("oob_rd%0d", i), i, 128'h0);
    check_keys(K2);

    // reset at round 5, then a clean expansion
    @(negedge clk);
    key   = K1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("round5_flags", 128'({busy, keys_valid}), 128'b10);
    async_reset_check("rst_mid");
    do_expand(K2, 1'b0);
    read_check("post_rst_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // random keys, random ignored starts
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      do_expand(rk, 1'($urandom_range(0, 1)));
      check_keys(rk);
      read_check("rand_oob", $urandom_range(11, 15), 128'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
